io_uart_tx: RTL and testbench

Memory-mapped UART transmitter that answers the stack machine's I/O bus. The CPU drives `io_addr`, `io_write` and `io_wr_data`, and reads `io_rd_data`. This block decodes its 16-word window, queues bytes written to its DATA register in a small FIFO, and serializes them 8N1 on `tx`. Status, divisor and overrun registers are readable in the same cycle as the address is presented, so CPU loads complete without wait states.

---
 rtl/io_uart_pkg.sv | 24 ++
 rtl/io_sync_fifo.sv | 52 +++++
 rtl/io_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_io_uart_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets inside the 16-word window, FSM encoding and STATUS bit layout.
package io_uart_pkg;

    localparam logic [3:0] REG_DATA    = 4'd0;
    localparam logic [3:0] REG_STATUS  = 4'd1;
    localparam logic [3:0] REG_DIVISOR = 4'd2;
    localparam logic [3:0] REG_OVERRUN = 4'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 4;
    localparam int STAT_W       = STAT_CNT_LSB + STAT_CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO. A push while full is
// accepted only if a pop happens in the same cycle; a pop while empty is
// ignored. Storage is not reset; only pointers and count are.
module io_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [0:(1<<PTR_W)-1];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Byte storage, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU I/O bus: window decode,
// DATA/STATUS/DIVISOR/OVERRUN registers, TX FIFO and serializer FSM.
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int                   CPU_WIDTH       = 16,
    parameter logic [CPU_WIDTH-1:0] BASE_ADDR       = 16'h4000,
    parameter int                   FIFO_DEPTH      = 4,
    parameter int                   DEFAULT_DIVISOR = 103
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CPU_WIDTH-1:0] io_addr,
    input  logic                 io_write,
    input  logic [CPU_WIDTH-1:0] io_wr_data,
    output logic [CPU_WIDTH-1:0] io_rd_data,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  hit;
    logic [3:0]            offset;
    logic                  wr_en;
    logic                  push_req;
    logic                  overrun_evt;
    logic [15:0]           divisor;
    logic [7:0]            overrun;
    logic [STAT_W-1:0]     status;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [7:0]            fifo_rd_data;

    uart_state_t           state, state_d;
    logic [15:0]           bit_cnt, bit_cnt_d;
    logic [2:0]            bit_idx, bit_idx_d;
    logic [7:0]            shift, shift_d;
    logic                  tx_d;
    logic                  pop;

    assign hit         = (io_addr[CPU_WIDTH-1:4] == BASE_ADDR[CPU_WIDTH-1:4]);
    assign offset      = io_addr[3:0];
    assign wr_en       = hit && io_write;
    assign push_req    = wr_en && (offset == REG_DATA);
    assign overrun_evt = push_req && fifo_full && !pop;

    io_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop),
        .wr_data (io_wr_data[7:0]),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // STATUS word assembled from live flags.
    always_comb begin
        status                                = '0;
        status[STAT_BUSY]                     = tx_busy;
        status[STAT_FULL]                     = fifo_full;
        status[STAT_EMPTY]                    = fifo_empty;
        status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
    end

    // Zero-wait-state read mux; misses and unmapped offsets read as zero.
    always_comb begin
        io_rd_data = '0;
        if (hit) begin
            case (offset)
                REG_STATUS:  io_rd_data = CPU_WIDTH'(status);
                REG_DIVISOR: io_rd_data = CPU_WIDTH'(divisor);
                REG_OVERRUN: io_rd_data = CPU_WIDTH'(overrun);
                default:     io_rd_data = '0;
            endcase
        end
    end

    // DIVISOR and OVERRUN registers; a clear beats a simultaneous drop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor <= 16'(DEFAULT_DIVISOR);
            overrun <= '0;
        end else begin
            if (wr_en && offset == REG_DIVISOR) divisor <= io_wr_data[15:0];
            if (wr_en && offset == REG_OVERRUN) overrun <= '0;
            else if (overrun_evt && overrun != 8'hFF) overrun <= overrun + 8'd1;
        end
    end

    // Serializer next state: each bit holds for DIVISOR+1 clocks, and the end
    // of STOP chains straight into the next START when a byte is waiting.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        tx_d      = tx;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rd_data;
                    bit_cnt_d = divisor;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_cnt == '0) begin
                    bit_cnt_d = divisor;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                    tx_d      = shift[0];
                end else begin
                    bit_cnt_d = bit_cnt - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_d = divisor;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift >> 1;
                        tx_d      = shift[1];
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_cnt == '0) begin
                    bit_cnt_d = divisor;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serializer control state; tx is forced high and the frame dropped on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            bit_idx <= bit_idx_d;
            tx      <= tx_d;
            tx_busy <= (state_d != ST_IDLE);
        end
    end

    // Shift register holds frame data only, so it carries no reset.
    always_ff @(posedge clock) begin
        shift <= shift_d;
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: register vector table, frame
// waveform checks against a bit-list model, overrun and reset corners.
module tb_io_uart_tx;
    import io_uart_pkg::*;

    localparam logic [15:0] BASE  = 16'h4000;
    localparam int          DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] io_addr;
    logic        io_write;
    logic [15:0] io_wr_data;
    logic [15:0] io_rd_data;
    logic        tx;
    logic        tx_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] wq[$];

    typedef struct {
        logic        wr;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[14];

    io_uart_tx #(
        .CPU_WIDTH       (16),
        .BASE_ADDR       (16'h4000),
        .FIFO_DEPTH      (4),
        .DEFAULT_DIVISOR (103)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_addr    (io_addr),
        .io_write   (io_write),
        .io_wr_data (io_wr_data),
        .io_rd_data (io_rd_data),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        io_addr    = a;
        io_write   = 1'b1;
        io_wr_data = d;
        @(negedge clock);
        io_write   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        io_addr  = a;
        io_write = 1'b0;
        #1;
        d = io_rd_data;
    endtask

    // STATUS expected right after the last of n consecutive DATA writes:
    // the first byte leaves the FIFO one cycle after it arrives, the rest stack up.
    function automatic logic [15:0] exp_status(input int n);
        int cnt;
        int busy;
        cnt  = (n >= 2) ? n - 1 : n;
        if (cnt > DEPTH) cnt = DEPTH;
        busy = (n >= 2) ? 1 : 0;
        return 16'(busy | ((cnt == DEPTH) ? 2 : 0) | ((cnt == 0) ? 4 : 0) | (cnt << 3));
    endfunction

    // Writes every byte in wq on consecutive cycles and compares tx/tx_busy
    // every clock with the concatenation of the expected 8N1 frames.
    task automatic burst(input string nm, input int d, output logic [15:0] st);
        bit exp_wave[$];
        int nacc;
        int len;
        int wbad;
        int bbad;
        logic exp_tx;
        logic exp_busy;
        nacc = (wq.size() > DEPTH + 1) ? DEPTH + 1 : wq.size();
        for (int b = 0; b < nacc; b++) begin
            for (int r = 0; r <= d; r++) exp_wave.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int r = 0; r <= d; r++) exp_wave.push_back(wq[b][i]);
            for (int r = 0; r <= d; r++) exp_wave.push_back(1'b1);
        end
        len  = exp_wave.size();
        wbad = 0;
        bbad = 0;
        st   = 'x;
        for (int c = 0; c <= len + 3; c++) begin
            @(negedge clock);
            exp_tx   = (c >= 2 && c - 2 < len) ? exp_wave[c-2] : 1'b1;
            exp_busy = (c >= 2 && c - 2 < len);
            if (tx !== exp_tx) wbad++;
            if (tx_busy !== exp_busy) bbad++;
            if (c < wq.size()) begin
                io_addr    = BASE;
                io_write   = 1'b1;
                io_wr_data = {8'($urandom), wq[c]};
            end else begin
                io_addr  = BASE + 16'd1;
                io_write = 1'b0;
            end
            if (c == wq.size()) begin
                #1;
                st = io_rd_data;
            end
        end
        check({nm, "_tx_wave_errs"}, wbad, 0);
        check({nm, "_busy_errs"}, bbad, 0);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] st;
        int          d;
        int          n;
        int          errs;

        reset      = 1'b0;
        io_addr    = '0;
        io_write   = 1'b0;
        io_wr_data = '0;
        repeat (3) @(negedge clock);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        vt[0]  = '{1'b0, 16'h0000, 16'h0000, BASE + 16'd1, 16'h0004};
        vt[1]  = '{1'b0, 16'h0000, 16'h0000, BASE + 16'd2, 16'd103};
        vt[2]  = '{1'b0, 16'h0000, 16'h0000, BASE + 16'd3, 16'h0000};
        vt[3]  = '{1'b0, 16'h0000, 16'h0000, BASE,         16'h0000};
        vt[4]  = '{1'b0, 16'h0000, 16'h0000, BASE + 16'd5, 16'h0000};
        vt[5]  = '{1'b1, BASE + 16'd5, 16'hFFFF, BASE + 16'd2, 16'd103};
        vt[6]  = '{1'b1, 16'h0002, 16'h0003, BASE + 16'd2, 16'd103};
        vt[7]  = '{1'b1, 16'h0000, 16'h00AA, BASE + 16'd1, 16'h0004};
        vt[8]  = '{1'b0, 16'h0000, 16'h0000, 16'h0002,     16'h0000};
        vt[9]  = '{1'b1, BASE + 16'd2, 16'h1234, BASE + 16'd2, 16'h1234};
        vt[10] = '{1'b1, 16'h4012, 16'h0007, BASE + 16'd2, 16'h1234};
        vt[11] = '{1'b0, 16'h0000, 16'h0000, 16'h4012,     16'h0000};
        vt[12] = '{1'b1, BASE + 16'd2, 16'h0003, BASE + 16'd2, 16'h0003};
        vt[13] = '{1'b0, 16'h0000, 16'h0000, BASE + 16'd1, 16'h0004};

        for (int i = 0; i < 14; i++) begin
            if (vt[i].wr) bus_write(vt[i].waddr, vt[i].wdata);
            bus_read(vt[i].raddr, rd);
            check($sformatf("vec%0d", i), rd, vt[i].exp);
        end

        // Single frame 8'hA5 at DIVISOR=3.
        wq = '{8'hA5};
        burst("a5_d3", 3, st);
        check("a5_status", st, exp_status(1));

        // Back-to-back frames at DIVISOR=0, no idle gap.
        bus_write(BASE + 16'd2, 16'd0);
        wq = '{8'h55, 8'hFF};
        burst("b2b_d0", 0, st);
        check("b2b_status", st, exp_status(2));

        // Six consecutive writes at DIVISOR=3: one byte dropped.
        bus_write(BASE + 16'd2, 16'd3);
        wq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
        burst("six_d3", 3, st);
        check("six_status", st, 16'h0023);
        bus_read(BASE + 16'd3, rd);
        check("six_overrun", rd, 16'd1);
        bus_write(BASE + 16'd3, 16'($urandom));
        bus_read(BASE + 16'd3, rd);
        check("overrun_clear", rd, 16'd0);

        // Randomized bursts against the frame model.
        for (int t = 0; t < 6; t++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(1, 5);
            bus_write(BASE + 16'd2, 16'(d));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
            burst($sformatf("rnd%0d", t), d, st);
            check($sformatf("rnd%0d_status", t), st, exp_status(n));
            bus_read(BASE + 16'd3, rd);
            check($sformatf("rnd%0d_overrun", t), rd, 16'd0);
        end

        // 305 writes during one long frame: 300 drops saturate OVERRUN.
        bus_write(BASE + 16'd2, 16'd1000);
        @(negedge clock);
        io_addr  = BASE;
        io_write = 1'b1;
        for (int i = 0; i < 305; i++) begin
            io_wr_data = 16'($urandom);
            @(negedge clock);
        end
        io_write = 1'b0;
        bus_read(BASE + 16'd3, rd);
        check("overrun_sat", rd, 16'd255);
        bus_read(BASE + 16'd1, rd);
        check("sat_status", rd, 16'h0023);
        check("sat_tx_start", tx, 1'b0);

        // Asynchronous reset during the start bit.
        reset = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        bus_read(BASE + 16'd1, rd);
        check("rst_status", rd, 16'h0004);
        bus_read(BASE + 16'd3, rd);
        check("rst_overrun", rd, 16'd0);
        bus_read(BASE + 16'd2, rd);
        check("rst_divisor", rd, 16'd103);
        @(negedge clock);
        reset = 1'b1;

        // Reset after the third data bit of 8'hA5 (bit 3 is 0).
        bus_write(BASE + 16'd2, 16'd3);
        bus_write(BASE, 16'h00A5);
        repeat (17) @(negedge clock);
        check("mid_busy_before", tx_busy, 1'b1);
        check("mid_tx_before", tx, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_tx_after", tx, 1'b1);
        bus_read(BASE + 16'd1, rd);
        check("mid_status", rd, 16'h0004);
        @(negedge clock);
        reset = 1'b1;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        check("mid_no_frame", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
